// File: rtl/intersection_phase_scheduler.sv
// Phase sequencer for a two-road intersection with a pedestrian crossing.
// Counts down each phase on a 1 Hz strobe and serves a latched walk request.
module intersection_phase_scheduler #(
   parameter int GREEN_A_S   = 20,
   parameter int GREEN_B_S   = 15,
   parameter int YELLOW_S    = 3,
   parameter int ALLRED_S    = 1,
   parameter int WALK_S      = 8,
   parameter int PED_SHORT_S = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_tick,
   input  logic       i_ped_req,
   output logic [1:0] o_state_a,
   output logic [1:0] o_state_b,
   output logic [6:0] o_remaining,
   output logic [2:0] o_phase,
   output logic       o_ped_walk,
   output logic       o_ped_ack
);

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      A_GREEN  = 3'd1,
      A_YELLOW = 3'd2,
      CLR_AB   = 3'd3,
      B_GREEN  = 3'd4,
      B_YELLOW = 3'd5,
      CLR_BA   = 3'd6
   } phase_t;

   localparam logic [6:0] DUR_GA  = 7'(GREEN_A_S);
   localparam logic [6:0] DUR_GB  = 7'(GREEN_B_S);
   localparam logic [6:0] DUR_Y   = 7'(YELLOW_S);
   localparam logic [6:0] DUR_CLR = 7'(ALLRED_S);
   localparam logic [6:0] DUR_WLK = 7'(WALK_S);
   localparam logic [6:0] DUR_PED = 7'(PED_SHORT_S);

   phase_t     state, state_nxt;
   logic [6:0] rem, rem_nxt;
   logic       walk, walk_nxt;
   logic       latch, latch_nxt;
   logic       ack_nxt;
   logic [1:0] light_a, light_b;
   logic [1:0] light_a_nxt, light_b_nxt;

   function automatic phase_t succ(input phase_t p);
      unique case (p)
         A_GREEN:  return A_YELLOW;
         A_YELLOW: return CLR_AB;
         CLR_AB:   return B_GREEN;
         B_GREEN:  return B_YELLOW;
         B_YELLOW: return CLR_BA;
         default:  return A_GREEN;
      endcase
   endfunction

   function automatic logic [6:0] dur(input phase_t p, input logic ped);
      unique case (p)
         A_GREEN:          return DUR_GA;
         B_GREEN:          return DUR_GB;
         A_YELLOW,
         B_YELLOW:         return DUR_Y;
         CLR_AB, CLR_BA:   return ped ? DUR_WLK : DUR_CLR;
         default:          return 7'd0;
      endcase
   endfunction

   logic is_green, is_clr;
   assign is_green = (state == A_GREEN) || (state == B_GREEN);
   assign is_clr   = (state == CLR_AB) || (state == CLR_BA);

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      walk_nxt  = walk;
      latch_nxt = latch;
      ack_nxt   = 1'b0;
      if (!i_en) begin
         state_nxt = OFF;
         rem_nxt   = 7'd0;
         walk_nxt  = 1'b0;
         latch_nxt = 1'b0;
      end else if (state == OFF) begin
         state_nxt = A_GREEN;
         rem_nxt   = DUR_GA;
      end else begin
         if (i_ped_req && !latch && !walk) begin
            latch_nxt = 1'b1;
            ack_nxt   = 1'b1;
         end
         // Truncation outranks a coincident tick.
         if (is_green && latch && rem > DUR_PED) begin
            rem_nxt = DUR_PED;
         end else if (i_tick) begin
            if (rem > 7'd1) begin
               rem_nxt = rem - 7'd1;
            end else begin
               state_nxt = succ(state);
               rem_nxt   = dur(succ(state), latch);
               if (is_clr) begin
                  walk_nxt  = 1'b0;
                  latch_nxt = 1'b0;
               end else if (succ(state) == CLR_AB ||
                            succ(state) == CLR_BA) begin
                  walk_nxt = latch;
               end
            end
         end
      end
   end

   always_comb begin
      light_a_nxt = 2'b01;
      light_b_nxt = 2'b01;
      unique case (state_nxt)
         A_GREEN:  light_a_nxt = 2'b11;
         A_YELLOW: light_a_nxt = 2'b10;
         B_GREEN:  light_b_nxt = 2'b11;
         B_YELLOW: light_b_nxt = 2'b10;
         default:  ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= OFF;
         rem       <= 7'd0;
         walk      <= 1'b0;
         latch     <= 1'b0;
         o_ped_ack <= 1'b0;
         light_a   <= 2'b01;
         light_b   <= 2'b01;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         walk      <= walk_nxt;
         latch     <= latch_nxt;
         o_ped_ack <= ack_nxt;
         light_a   <= light_a_nxt;
         light_b   <= light_b_nxt;
      end
   end

   assign o_phase     = state;
   assign o_remaining = rem;
   assign o_ped_walk  = walk;
   assign o_state_a   = light_a;
   assign o_state_b   = light_b;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus random
// stimulus compared cycle by cycle with a table-driven reference model.
module tb_intersection_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst, en, tick, ped_req;
   logic [1:0] state_a, state_b;
   logic [6:0] remaining;
   logic [2:0] phase;
   logic       ped_walk, ped_ack;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: phase index, seconds left, walk, request latch, ack.
   int m_ph, m_rem, m_walk, m_latch, m_ack;
   int dur_tab [7] = '{0, 20, 3, 1, 15, 3, 1};
   int la_tab  [7] = '{1, 3, 2, 1, 1, 1, 1};
   int lb_tab  [7] = '{1, 1, 1, 1, 3, 2, 1};
   localparam int WALK_SEC = 8;
   localparam int SHORT_SEC = 5;

   intersection_phase_scheduler dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_tick      (tick),
      .i_ped_req   (ped_req),
      .o_state_a   (state_a),
      .o_state_b   (state_b),
      .o_remaining (remaining),
      .o_phase     (phase),
      .o_ped_walk  (ped_walk),
      .o_ped_ack   (ped_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_clr(input int p);
      return p == 3 || p == 6;
   endfunction

   task automatic model_step(input bit r, input bit e, input bit t,
                             input bit q);
      int ph, rm, wk, lt, ak;
      ph = m_ph; rm = m_rem; wk = m_walk; lt = m_latch; ak = 0;
      if (r || !e) begin
         ph = 0; rm = 0; wk = 0; lt = 0;
      end else if (m_ph == 0) begin
         ph = 1; rm = dur_tab[1];
      end else begin
         if (q && m_latch == 0 && m_walk == 0) begin
            lt = 1; ak = 1;
         end
         if ((m_ph == 1 || m_ph == 4) && m_latch == 1 && m_rem > SHORT_SEC)
            rm = SHORT_SEC;
         else if (t && m_rem > 1)
            rm = m_rem - 1;
         else if (t) begin
            ph = (m_ph % 6) + 1;
            rm = is_clr(ph) ? (m_latch ? WALK_SEC : dur_tab[ph]) : dur_tab[ph];
            if (is_clr(m_ph)) begin
               wk = 0; lt = 0;
            end else if (is_clr(ph)) begin
               wk = m_latch;
            end
         end
      end
      m_ph = ph; m_rem = rm; m_walk = wk; m_latch = lt; m_ack = ak;
   endtask

   task automatic cyc(input bit r, input bit e, input bit t, input bit q);
      rst = r; en = e; tick = t; ped_req = q;
      @(posedge clk);
      model_step(r, e, t, q);
      @(negedge clk);
      check("phase", phase, m_ph);
      check("light_a", state_a, la_tab[m_ph]);
      check("light_b", state_b, lb_tab[m_ph]);
      check("remaining", remaining, m_rem);
      check("walk", ped_walk, m_walk);
      check("ack", ped_ack, m_ack);
   endtask

   task automatic sec(input bit q);
      cyc(0, 1, 1, q);
      cyc(0, 1, 0, 0);
   endtask

   task automatic run_to(input int ph, input int rm);
      int k;
      for (k = 0; k < 200; k++) begin
         if (m_ph == ph && m_rem == rm) break;
         sec(0);
      end
      check("run_to_reached", int'(k < 200), 1);
   endtask

   initial begin
      rst = 1; en = 0; tick = 0; ped_req = 0;
      m_ph = 0; m_rem = 0; m_walk = 0; m_latch = 0; m_ack = 0;
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      check("reset_phase", phase, 0);
      check("reset_rem", remaining, 0);
      cyc(0, 1, 0, 0);
      check("start_rem", remaining, 20);
      check("start_a", state_a, 3);
      for (int i = 0; i < 20; i++) sec(0);
      check("a_yellow", phase, 2);
      check("a_yellow_rem", remaining, 3);
      for (int i = 0; i < 3; i++) sec(0);
      check("clr_ab_rem", remaining, 1);
      sec(0);
      check("b_green_rem", remaining, 15);
      for (int i = 0; i < 19; i++) sec(0);
      check("full_cycle_phase", phase, 1);
      check("full_cycle_rem", remaining, 20);
      // Request truncates a long green.
      run_to(1, 12);
      cyc(0, 1, 0, 1);
      check("ack_pulse", ped_ack, 1);
      cyc(0, 1, 0, 0);
      check("trunc_rem", remaining, 5);
      check("ack_gone", ped_ack, 0);
      for (int i = 0; i < 8; i++) sec(0);
      check("walk_on", ped_walk, 1);
      check("walk_rem", remaining, 8);
      for (int i = 0; i < 8; i++) sec(0);
      check("walk_off_phase", phase, 4);
      check("walk_off", ped_walk, 0);
      // Short green: ack but no truncation; request during walk ignored.
      run_to(1, 4);
      cyc(0, 1, 0, 1);
      check("short_ack", ped_ack, 1);
      cyc(0, 1, 0, 0);
      check("no_trunc", remaining, 4);
      run_to(3, 5);
      cyc(0, 1, 0, 1);
      check("walk_req_noack", ped_ack, 0);
      run_to(4, 15);
      cyc(0, 1, 0, 0);
      check("b_not_trunc", remaining, 15);
      // Request coincident with a tick at 9.
      run_to(1, 9);
      cyc(0, 1, 1, 1);
      cyc(0, 1, 0, 0);
      check("tick_req_rem", remaining, 5);
      // Disable in B_YELLOW, re-enable, reset mid-walk.
      run_to(5, 2);
      cyc(0, 0, 0, 0);
      check("dis_phase", phase, 0);
      check("dis_rem", remaining, 0);
      cyc(0, 1, 0, 0);
      check("reen_rem", remaining, 20);
      cyc(0, 1, 0, 1);
      run_to(3, 6);
      check("pre_rst_walk", ped_walk, 1);
      cyc(1, 1, 0, 0);
      check("rst_walk", ped_walk, 0);
      check("rst_phase", phase, 0);
      // Random traffic.
      for (int i = 0; i < 6000; i++) begin
         cyc(($urandom % 700) == 0, ($urandom % 80) != 0,
             ($urandom % 3) == 0, ($urandom % 12) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
